// File: rtl/cmd_mailbox_pkg.sv
// Shared definitions for the N64<->CPU command mailbox: status bit layout,
// control-word bit positions, the queued entry type and the CPU-side states.
package cmd_mailbox_pkg;

  localparam int WORD_W = 32;

  // Status word layout seen by the N64 at address 0
  localparam int STAT_READY_BIT = 31;
  localparam int STAT_BUSY_BIT  = 30;
  localparam int STAT_ERROR_BIT = 29;
  localparam int STAT_FULL_BIT  = 28;
  localparam int STAT_IRQ_BIT   = 27;
  localparam int STAT_CNT_LSB   = 24;

  // Control bits in a write to address 0 that suppress the push
  localparam int ERR_CLEAR_BIT = 31;
  localparam int IRQ_CLEAR_BIT = 30;

  // Default-geometry entry; the top overrides the FIFO type with its own widths
  localparam int DEF_CMD_W      = 8;
  localparam int DEF_DATA_WORDS = 2;

  typedef struct packed {
    logic [DEF_CMD_W-1:0]                  cmd;
    logic [DEF_DATA_WORDS-1:0][WORD_W-1:0] data;
  } mbox_entry_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } cpu_state_e;

endpackage

// File: rtl/cmd_mailbox_fifo.sv
// Small synchronous FIFO of command entries with a combinational head view,
// so a push into an empty queue is visible on the following cycle.
module cmd_mailbox_fifo
  import cmd_mailbox_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mbox_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a pop cannot make room for a same-cycle push
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr_reg] <= push_data;
        wr_ptr_reg      <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/cmd_mailbox.sv
// N64<->CPU command mailbox: N64 writes argument words then a command, which is
// queued with a data snapshot; firmware pops, writes results and reports done/error.
// Optional interrupt output enabled by defining CMD_MAILBOX_IRQ_EN.
module cmd_mailbox
  import cmd_mailbox_pkg::*;
#(
  parameter int  DATA_WORDS  = 2,
  parameter int  QUEUE_DEPTH = 4,
  parameter int  CMD_W       = 8,
  localparam int AW          = $clog2(DATA_WORDS + 1),
  localparam int CNT_W       = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       n64_write,
  input  logic                       n64_read,
  input  logic [AW-1:0]              n64_addr,
  input  logic [31:0]                n64_wdata,
  output logic [31:0]                n64_rdata,
  input  logic                       cpu_ready,
  output logic                       cpu_cmd_valid,
  output logic [CMD_W-1:0]           cpu_cmd,
  output logic [DATA_WORDS*32-1:0]   cpu_data,
  input  logic                       cpu_cmd_ack,
  input  logic                       cpu_done,
  input  logic                       cpu_error,
  input  logic [DATA_WORDS-1:0]      cpu_data_write,
  input  logic [31:0]                cpu_wdata
`ifdef CMD_MAILBOX_IRQ_EN
  ,
  output logic                       irq
`endif
);

  typedef struct packed {
    logic [CMD_W-1:0]                  cmd;
    logic [DATA_WORDS-1:0][WORD_W-1:0] data;
  } entry_t;

  logic [DATA_WORDS-1:0][WORD_W-1:0] data_reg;
  logic [CMD_W-1:0]                  last_cmd_reg;
  logic                              error_reg;
  cpu_state_e                        state_reg;
  cpu_state_e                        state_next;

  entry_t           push_entry;
  entry_t           head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic        cmd_write;
  logic        ctrl_write;
  logic        err_clear;
  logic        push_req;
  logic        push_ok;
  logic        push_reject;
  logic        pop;
  logic        done_evt;
  logic        busy;
  logic [31:0] status;
  logic [31:0] rd_word;

  // Writes to address 0 carrying a clear bit are control writes and never push
  assign cmd_write = n64_write && (n64_addr == '0);
  assign err_clear = cmd_write && n64_wdata[ERR_CLEAR_BIT];
`ifdef CMD_MAILBOX_IRQ_EN
  logic irq_reg;
  logic irq_clear;
  assign irq_clear  = cmd_write && n64_wdata[IRQ_CLEAR_BIT];
  assign ctrl_write = n64_wdata[ERR_CLEAR_BIT] || n64_wdata[IRQ_CLEAR_BIT];
`else
  assign ctrl_write = n64_wdata[ERR_CLEAR_BIT];
`endif
  assign push_req    = cmd_write && !ctrl_write;
  assign push_ok     = push_req && cpu_ready && !fifo_full;
  assign push_reject = push_req && !(cpu_ready && !fifo_full);

  // The snapshot is the registered data, i.e. before any same-cycle data write
  assign push_entry.cmd  = n64_wdata[CMD_W-1:0];
  assign push_entry.data = data_reg;

  cmd_mailbox_fifo #(
    .DEPTH   (QUEUE_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pop           = 1'b0;
    cpu_cmd_valid = 1'b0;
    done_evt      = 1'b0;
    case (state_reg)
      IDLE: begin
        cpu_cmd_valid = !fifo_empty;
        if (cpu_cmd_ack && !fifo_empty) begin
          pop        = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cpu_done) begin
          done_evt   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign cpu_cmd  = head_entry.cmd;
  assign cpu_data = head_entry.data;

  // Firmware result writes take priority over N64 argument writes to the same word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
    end else begin
      for (int i = 0; i < DATA_WORDS; i++) begin
        if (cpu_data_write[i]) begin
          data_reg[i] <= cpu_wdata;
        end else if (n64_write && (n64_addr == AW'(i + 1))) begin
          data_reg[i] <= n64_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cmd_reg <= '0;
      error_reg    <= 1'b0;
    end else begin
      if (push_ok) begin
        last_cmd_reg <= n64_wdata[CMD_W-1:0];
      end
      if (err_clear) begin
        error_reg <= 1'b0;
      end else if (push_reject || (done_evt && cpu_error)) begin
        error_reg <= 1'b1;
      end
    end
  end

`ifdef CMD_MAILBOX_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_reg <= 1'b0;
    end else if (done_evt) begin
      irq_reg <= 1'b1;
    end else if (irq_clear) begin
      irq_reg <= 1'b0;
    end
  end
  assign irq = irq_reg;
`endif

  assign busy = (fifo_count != '0) || (state_reg == ACTIVE);

  always_comb begin
    status                 = '0;
    status[CMD_W-1:0]      = last_cmd_reg;
`ifdef CMD_MAILBOX_IRQ_EN
    status[STAT_CNT_LSB +: 3] = (fifo_count > CNT_W'(7)) ? 3'd7 : 3'(fifo_count);
    status[STAT_IRQ_BIT]      = irq_reg;
`else
    status[STAT_CNT_LSB +: 4] = (fifo_count > CNT_W'(15)) ? 4'd15 : 4'(fifo_count);
`endif
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_ERROR_BIT] = error_reg;
    status[STAT_BUSY_BIT]  = busy;
    status[STAT_READY_BIT] = cpu_ready;
  end

  always_comb begin
    rd_word = '0;
    if (n64_addr == '0) begin
      rd_word = status;
    end
    for (int i = 0; i < DATA_WORDS; i++) begin
      if (n64_addr == AW'(i + 1)) begin
        rd_word = data_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n64_rdata <= '0;
    end else if (n64_read) begin
      n64_rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_cmd_mailbox.sv
// Directed self-checking bench for cmd_mailbox in its default configuration
// (DATA_WORDS=2, QUEUE_DEPTH=4, CMD_W=8, interrupt disabled).
module tb_cmd_mailbox;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        n64_write;
  logic        n64_read;
  logic [1:0]  n64_addr;
  logic [31:0] n64_wdata;
  logic [31:0] n64_rdata;
  logic        cpu_ready;
  logic        cpu_cmd_valid;
  logic [7:0]  cpu_cmd;
  logic [63:0] cpu_data;
  logic        cpu_cmd_ack;
  logic        cpu_done;
  logic        cpu_error;
  logic [1:0]  cpu_data_write;
  logic [31:0] cpu_wdata;
`ifdef CMD_MAILBOX_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  cmd_mailbox dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .n64_write      (n64_write),
    .n64_read       (n64_read),
    .n64_addr       (n64_addr),
    .n64_wdata      (n64_wdata),
    .n64_rdata      (n64_rdata),
    .cpu_ready      (cpu_ready),
    .cpu_cmd_valid  (cpu_cmd_valid),
    .cpu_cmd        (cpu_cmd),
    .cpu_data       (cpu_data),
    .cpu_cmd_ack    (cpu_cmd_ack),
    .cpu_done       (cpu_done),
    .cpu_error      (cpu_error),
    .cpu_data_write (cpu_data_write),
    .cpu_wdata      (cpu_wdata)
`ifdef CMD_MAILBOX_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic n64_wr(input logic [1:0] a, input logic [31:0] d);
    n64_write = 1'b1;
    n64_addr  = a;
    n64_wdata = d;
    cycle();
    n64_write = 1'b0;
  endtask

  task automatic n64_rd(input logic [1:0] a, output logic [31:0] d);
    n64_read = 1'b1;
    n64_addr = a;
    cycle();
    n64_read = 1'b0;
    d = n64_rdata;
  endtask

  task automatic cpu_ack();
    cpu_cmd_ack = 1'b1;
    cycle();
    cpu_cmd_ack = 1'b0;
  endtask

  task automatic cpu_finish(input logic err);
    cpu_done  = 1'b1;
    cpu_error = err;
    cycle();
    cpu_done  = 1'b0;
    cpu_error = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    n64_write      = 1'b0;
    n64_read       = 1'b0;
    n64_addr       = '0;
    n64_wdata      = '0;
    cpu_ready      = 1'b0;
    cpu_cmd_ack    = 1'b0;
    cpu_done       = 1'b0;
    cpu_error      = 1'b0;
    cpu_data_write = '0;
    cpu_wdata      = '0;
    repeat (2) @(negedge clk);

    check("rst_rdata", 64'(n64_rdata), 64'h0);
    check("rst_valid", 64'(cpu_cmd_valid), 64'h0);
    check("rst_cmd", 64'(cpu_cmd), 64'h0);
    check("rst_data", cpu_data, 64'h0);

    reset_n   = 1'b1;
    cpu_ready = 1'b1;
    @(negedge clk);

    // Basic command with two argument words
    n64_wr(2'd1, 32'h11223344);
    n64_wr(2'd2, 32'hAABBCCDD);
    n64_wr(2'd0, 32'h00000005);
    check("push_valid", 64'(cpu_cmd_valid), 64'h1);
    check("push_cmd", 64'(cpu_cmd), 64'h05);
    check("push_data", cpu_data, 64'hAABBCCDD_11223344);
    n64_rd(2'd0, rd);
    check("status_one", 64'(rd), 64'hC1000005);

    // Fill to depth, overflow, clear error
    n64_wr(2'd0, 32'h10);
    n64_wr(2'd0, 32'h11);
    n64_wr(2'd0, 32'h12);
    n64_rd(2'd0, rd);
    check("status_full", 64'(rd), 64'hD4000012);
    n64_wr(2'd0, 32'h13);
    n64_rd(2'd0, rd);
    check("status_overflow", 64'(rd), 64'hF4000012);
    check("head_after_ovf", 64'(cpu_cmd), 64'h05);
    n64_wr(2'd0, 32'h80000000);
    n64_rd(2'd0, rd);
    check("status_err_clr", 64'(rd), 64'hD4000012);

    // Ack head; second ack in ACTIVE is ignored
    cpu_ack();
    check("active_valid", 64'(cpu_cmd_valid), 64'h0);
    cpu_ack();
    n64_rd(2'd0, rd);
    check("status_active", 64'(rd), 64'hC3000012);
    cpu_data_write = 2'b01;
    cpu_wdata      = 32'hDEADBEEF;
    cycle();
    cpu_data_write = 2'b00;
    cpu_finish(1'b0);
    check("next_valid", 64'(cpu_cmd_valid), 64'h1);
    check("next_data_snap", cpu_data, 64'hAABBCCDD_11223344);

    // Drain the rest, checking order
    for (int i = 0; i < 3; i++) begin
      check("drain_cmd", 64'(cpu_cmd), 64'(8'h10 + i));
      cpu_ack();
      cpu_finish(1'b0);
    end
    check("drained_valid", 64'(cpu_cmd_valid), 64'h0);
    n64_rd(2'd1, rd);
    check("result_word0", 64'(rd), 64'hDEADBEEF);
    n64_rd(2'd2, rd);
    check("word1_kept", 64'(rd), 64'hAABBCCDD);
    n64_rd(2'd0, rd);
    check("status_idle", 64'(rd), 64'h80000012);
    cycle();
    check("rdata_hold", 64'(n64_rdata), 64'h80000012);

    // Push while not ready
    cpu_ready = 1'b0;
    n64_wr(2'd0, 32'h07);
    check("notready_valid", 64'(cpu_cmd_valid), 64'h0);
    n64_rd(2'd0, rd);
    check("status_notready", 64'(rd), 64'h20000012);
    n64_wr(2'd0, 32'h80000000);
    cpu_ready = 1'b1;

    // Same-word conflict: CPU write wins
    n64_write      = 1'b1;
    n64_addr       = 2'd1;
    n64_wdata      = 32'h1;
    cpu_data_write = 2'b01;
    cpu_wdata      = 32'h2;
    cycle();
    n64_write      = 1'b0;
    cpu_data_write = 2'b00;
    n64_rd(2'd1, rd);
    check("conflict_word0", 64'(rd), 64'h2);

    // Snapshot excludes a same-cycle result write
    n64_write      = 1'b1;
    n64_addr       = 2'd0;
    n64_wdata      = 32'h21;
    cpu_data_write = 2'b01;
    cpu_wdata      = 32'h33;
    cycle();
    n64_write      = 1'b0;
    cpu_data_write = 2'b00;
    check("snap_cmd", 64'(cpu_cmd), 64'h21);
    check("snap_data", cpu_data, 64'hAABBCCDD_00000002);
    n64_rd(2'd1, rd);
    check("snap_word0_new", 64'(rd), 64'h33);
    cpu_ack();
    cpu_finish(1'b1);
    n64_rd(2'd0, rd);
    check("status_cpu_err", 64'(rd), 64'hA0000021);
    n64_rd(2'd3, rd);
    check("unmapped_addr", 64'(rd), 64'h0);

    // Error clear coincident with cpu_error on done: clear wins
    n64_wr(2'd0, 32'h22);
    cpu_ack();
    n64_write = 1'b1;
    n64_addr  = 2'd0;
    n64_wdata = 32'h80000000;
    cpu_done  = 1'b1;
    cpu_error = 1'b1;
    cycle();
    n64_write = 1'b0;
    cpu_done  = 1'b0;
    cpu_error = 1'b0;
    n64_rd(2'd0, rd);
    check("clear_wins", 64'(rd), 64'h80000022);

    // Reset with one in flight and two queued
    n64_wr(2'd0, 32'h31);
    n64_wr(2'd0, 32'h32);
    n64_wr(2'd0, 32'h33);
    cpu_ack();
    check("inflight_valid", 64'(cpu_cmd_valid), 64'h0);
    check("inflight_head", 64'(cpu_cmd), 64'h32);
    reset_n = 1'b0;
    #1;
    check("midrst_rdata", 64'(n64_rdata), 64'h0);
    check("midrst_valid", 64'(cpu_cmd_valid), 64'h0);
    check("midrst_cmd", 64'(cpu_cmd), 64'h0);
    check("midrst_data", cpu_data, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n64_rd(2'd0, rd);
    check("status_post_rst", 64'(rd), 64'h80000000);
    check("post_rst_valid", 64'(cpu_cmd_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
